// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG run-length/category stage.
// Symbol field widths track the default coefficient and size widths.
package jpeg_pkg;

    localparam int BLOCK_COEFS = 64;
    localparam int ZRL_RUN     = 15;
    localparam int SYM_COEF_W  = 12;
    localparam int SYM_SIZE_W  = 4;

    typedef enum logic [0:0] {
        ACCEPT = 1'b0,
        FLUSH  = 1'b1
    } state_e;

    typedef struct packed {
        logic [3:0]            run;
        logic [SYM_SIZE_W-1:0] size;
        logic [SYM_COEF_W-1:0] amp;
        logic                  dc;
        logic                  last;
    } symbol_t;

    function automatic symbol_t make_sym(
        input logic [3:0]            run,
        input logic [SYM_SIZE_W-1:0] size,
        input logic [SYM_COEF_W-1:0] amp,
        input logic                  dc,
        input logic                  last
    );
        symbol_t s;
        s.run  = run;
        s.size = size;
        s.amp  = amp;
        s.dc   = dc;
        s.last = last;
        return s;
    endfunction

endpackage

// File: rtl/jpeg_size_cat.sv
// Magnitude category and right-aligned amplitude bits of a signed value.
// Input is one bit wider than a coefficient so DC differences fit.
module jpeg_size_cat #(
    parameter int COEF_W = 12,
    parameter int SIZE_W = 4
) (
    input  logic [COEF_W:0]   val_i,
    output logic [SIZE_W-1:0] size_o,
    output logic [COEF_W-1:0] amp_o
);

    logic [COEF_W:0]   mag;
    logic [COEF_W:0]   val_m1;
    logic [COEF_W-1:0] mask;

    always_comb begin
        mag    = val_i[COEF_W] ? (~val_i + 1'b1) : val_i;
        val_m1 = val_i + {(COEF_W + 1){1'b1}};
        size_o = '0;
        for (int i = 0; i <= COEF_W; i++) begin
            if (mag[i]) size_o = SIZE_W'(i + 1);
        end
        mask = '0;
        for (int i = 0; i < COEF_W; i++) begin
            if (i < int'(size_o)) mask[i] = 1'b1;
        end
        // Negative values use the one's-complement form, clipped to size bits.
        amp_o = val_i[COEF_W] ? (val_m1[COEF_W-1:0] & mask) : val_i[COEF_W-1:0];
    end

endmodule

// File: rtl/jpeg_rle_encoder.sv
// Turns a zig-zag coefficient stream into (run, size, amp) symbols with
// DC differencing, ZRL and EOB insertion, behind one output register.
module jpeg_rle_encoder
    import jpeg_pkg::*;
#(
    parameter int COEF_W = SYM_COEF_W,
    parameter int SIZE_W = SYM_SIZE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_pred,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_coef,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_run,
    output logic [SIZE_W-1:0] out_size,
    output logic [COEF_W-1:0] out_amp,
    output logic              out_dc,
    output logic              out_last,
    output logic [0:0]        dbg_state_o
);

    // Handshake: a word moves on a rising edge where valid && ready; valid and
    // its data stay stable until taken, and ready never depends on valid.
    localparam logic [0:0] S_ACCEPT = ACCEPT;
    localparam logic [0:0] S_FLUSH  = FLUSH;

    logic [0:0]        state_q, state_d;
    logic [5:0]        idx_q, idx_d;
    logic [5:0]        run_q, run_d;
    logic [COEF_W-1:0] pred_q, pred_d;
    logic              clr_pend_q, clr_pend_d;
    logic [COEF_W-1:0] held_q, held_d;
    logic              held_last_q, held_last_d;
    logic              out_valid_q, out_valid_d;
    symbol_t           sym_q, sym_d;

    logic              slot_free;
    logic              accept;
    logic              is_dc;
    logic              is_last_idx;
    logic [COEF_W:0]   coef_ext;
    logic [COEF_W:0]   pred_ext;
    logic [COEF_W:0]   cat_in;
    logic [SIZE_W-1:0] cat_size;
    logic [COEF_W-1:0] cat_amp;

    jpeg_size_cat #(
        .COEF_W (COEF_W),
        .SIZE_W (SIZE_W)
    ) u_size_cat (
        .val_i  (cat_in),
        .size_o (cat_size),
        .amp_o  (cat_amp)
    );

    assign slot_free   = !out_valid_q || out_ready;
    assign in_ready    = (state_q == S_ACCEPT) && slot_free;
    assign accept      = in_valid && in_ready;
    assign is_dc       = (idx_q == 6'd0);
    assign is_last_idx = (idx_q == 6'(BLOCK_COEFS - 1));
    assign coef_ext    = {in_coef[COEF_W-1], in_coef};
    assign pred_ext    = (clr_pred || clr_pend_q) ? '0 : {pred_q[COEF_W-1], pred_q};

    // The category unit is shared: held coefficient in FLUSH, else DC diff or AC value.
    always_comb begin
        if (state_q == S_FLUSH) begin
            cat_in = {held_q[COEF_W-1], held_q};
        end else if (is_dc) begin
            cat_in = coef_ext - pred_ext;
        end else begin
            cat_in = coef_ext;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        run_d       = run_q;
        pred_d      = pred_q;
        clr_pend_d  = clr_pend_q;
        held_d      = held_q;
        held_last_d = held_last_q;
        sym_d       = sym_q;
        out_valid_d = out_valid_q && !out_ready;

        if (accept && is_dc) begin
            clr_pend_d = 1'b0;
        end else if (clr_pred) begin
            clr_pend_d = 1'b1;
        end

        if (accept) begin
            idx_d = idx_q + 6'd1;
            if (is_dc) begin
                sym_d       = make_sym(4'd0, cat_size, cat_amp, 1'b1, 1'b0);
                out_valid_d = 1'b1;
                pred_d      = in_coef;
                run_d       = 6'd0;
            end else if (in_coef == '0) begin
                if (is_last_idx) begin
                    sym_d       = make_sym(4'd0, '0, '0, 1'b0, 1'b1);
                    out_valid_d = 1'b1;
                    run_d       = 6'd0;
                end else begin
                    run_d = run_q + 6'd1;
                end
            end else if (run_q < 6'd16) begin
                sym_d       = make_sym(run_q[3:0], cat_size, cat_amp, 1'b0, is_last_idx);
                out_valid_d = 1'b1;
                run_d       = 6'd0;
            end else begin
                sym_d       = make_sym(4'(ZRL_RUN), '0, '0, 1'b0, 1'b0);
                out_valid_d = 1'b1;
                run_d       = run_q - 6'd16;
                held_d      = in_coef;
                held_last_d = is_last_idx;
                state_d     = S_FLUSH;
            end
        end else if (state_q == S_FLUSH && slot_free) begin
            out_valid_d = 1'b1;
            if (run_q >= 6'd16) begin
                sym_d = make_sym(4'(ZRL_RUN), '0, '0, 1'b0, 1'b0);
                run_d = run_q - 6'd16;
            end else begin
                sym_d   = make_sym(run_q[3:0], cat_size, cat_amp, 1'b0, held_last_q);
                run_d   = 6'd0;
                state_d = S_ACCEPT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ACCEPT;
            idx_q       <= '0;
            run_q       <= '0;
            pred_q      <= '0;
            clr_pend_q  <= 1'b0;
            held_q      <= '0;
            held_last_q <= 1'b0;
            out_valid_q <= 1'b0;
            sym_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            run_q       <= run_d;
            pred_q      <= pred_d;
            clr_pend_q  <= clr_pend_d;
            held_q      <= held_d;
            held_last_q <= held_last_d;
            out_valid_q <= out_valid_d;
            sym_q       <= sym_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_run     = sym_q.run;
    assign out_size    = sym_q.size;
    assign out_amp     = sym_q.amp;
    assign out_dc      = sym_q.dc;
    assign out_last    = sym_q.last;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_jpeg_rle_encoder.sv
// Bench for jpeg_rle_encoder: directed and random blocks against a
// block-level symbol model, with random and forced output backpressure.
module tb_jpeg_rle_encoder;

    localparam int COEF_W = 12;
    localparam int SIZE_W = 4;
    localparam int SYM_W  = 4 + SIZE_W + COEF_W + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr_pred;
    logic              in_valid;
    logic              in_ready;
    logic [COEF_W-1:0] in_coef;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_run;
    logic [SIZE_W-1:0] out_size;
    logic [COEF_W-1:0] out_amp;
    logic              out_dc;
    logic              out_last;
    logic [0:0]        dbg_state;

    jpeg_rle_encoder #(.COEF_W(COEF_W), .SIZE_W(SIZE_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr_pred    (clr_pred),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_coef     (in_coef),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_run     (out_run),
        .out_size    (out_size),
        .out_amp     (out_amp),
        .out_dc      (out_dc),
        .out_last    (out_last),
        .dbg_state_o (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    logic [SYM_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int stall_n  = 0;
    bit sb_en    = 1'b0;
    int ref_pred = 0;
    bit pend_clr = 1'b0;
    int blk[64];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [SYM_W-1:0] pack(input int run, input int size, input int amp,
                                              input bit dc, input bit last);
        return {4'(run), SIZE_W'(size), COEF_W'(amp), dc, last};
    endfunction

    // Reference model: JPEG category/amplitude rules in plain integer arithmetic
    function automatic int cat_of(input int v);
        int m = (v < 0) ? -v : v;
        int c = 0;
        while (m > 0) begin
            c++;
            m = m >> 1;
        end
        return c;
    endfunction

    function automatic int amp_of(input int v);
        int c = cat_of(v);
        if (v >= 0) return v;
        return (v - 1) & ((1 << c) - 1);
    endfunction

    task automatic model_block(input int clr_idx);
        int diff;
        int run = 0;
        diff = blk[0] - ((pend_clr || clr_idx == 0) ? 0 : ref_pred);
        exp_q.push_back(pack(0, cat_of(diff), amp_of(diff), 1'b1, 1'b0));
        ref_pred = blk[0];
        pend_clr = (clr_idx > 0);
        for (int k = 1; k < 64; k++) begin
            if (blk[k] == 0) begin
                if (k == 63) exp_q.push_back(pack(0, 0, 0, 1'b0, 1'b1));
                else run++;
            end else begin
                while (run >= 16) begin
                    exp_q.push_back(pack(15, 0, 0, 1'b0, 1'b0));
                    run -= 16;
                end
                exp_q.push_back(pack(run, cat_of(blk[k]), amp_of(blk[k]), 1'b0, k == 63));
                run = 0;
            end
        end
    endtask

    // Stimulus helpers
    function automatic int rand_coef();
        int sz;
        int v;
        if ($urandom_range(0, 15) == 0) return ($urandom_range(0, 1) != 0) ? 2047 : -2048;
        sz = int'($urandom_range(1, 11));
        v  = int'($urandom_range(1 << (sz - 1), (1 << sz) - 1));
        return ($urandom_range(0, 1) != 0) ? -v : v;
    endfunction

    task automatic clear_blk();
        for (int k = 0; k < 64; k++) blk[k] = 0;
    endtask

    task automatic gen_blk(input int density);
        for (int k = 0; k < 64; k++) begin
            blk[k] = (int'($urandom_range(0, 99)) < density) ? rand_coef() : 0;
        end
        if ($urandom_range(0, 3) != 0) blk[0] = rand_coef();
    endtask

    // Driver: called at a negedge, returns at the negedge after the accept edge
    task automatic send_coef(input int c, input bit clr);
        int guard = 0;
        if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_coef  = COEF_W'(c);
        clr_pred = clr;
        forever begin
            #1;
            if (in_ready) begin
                @(negedge clk);
                break;
            end
            @(negedge clk);
            guard++;
            if (guard > 1000) begin
                check_eq("accept_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
        clr_pred = 1'b0;
    endtask

    task automatic run_block(input int clr_idx, input int stall_at);
        model_block(clr_idx);
        for (int k = 0; k < 64; k++) begin
            if (k == stall_at) stall_n = 5;
            send_coef(blk[k], k == clr_idx);
        end
    endtask

    task automatic check_reset_outputs();
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_run", 32'(out_run), 32'd0);
        check_eq("rst_out_size", 32'(out_size), 32'd0);
        check_eq("rst_out_amp", 32'(out_amp), 32'd0);
        check_eq("rst_out_dc", 32'(out_dc), 32'd0);
        check_eq("rst_out_last", 32'(out_last), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Sink: drives out_ready, checks every accepted symbol and hold stability
    initial begin
        logic [SYM_W-1:0] cur;
        logic [SYM_W-1:0] held_sym = '0;
        bit held_valid = 1'b0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_n > 0) begin
                out_ready = 1'b0;
                stall_n--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            #2;
            cur = {out_run, out_size, out_amp, out_dc, out_last};
            if (sb_en && !rst) begin
                if (held_valid) begin
                    check_eq("hold_valid", 32'(out_valid), 32'd1);
                    check_eq("hold_sym", 32'(cur), 32'(held_sym));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check_eq("extra_sym", 32'(out_valid), 32'd0);
                    else check_eq("sym", 32'(cur), 32'(exp_q.pop_front()));
                end
                if (out_valid && !out_ready) check_eq("in_ready_blocked", 32'(in_ready), 32'd0);
                held_valid = out_valid && !out_ready;
                held_sym   = cur;
            end else begin
                held_valid = 1'b0;
            end
        end
    end

    // Main sequence
    initial begin
        int guard;
        rst      = 1'b1;
        clr_pred = 1'b0;
        in_valid = 1'b0;
        in_coef  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();
        @(negedge clk);
        sb_en = 1'b1;

        clear_blk(); blk[0] = 5;
        run_block(-1, -1);
        clear_blk(); blk[0] = 3;
        run_block(-1, -1);
        clear_blk(); blk[0] = 3; blk[1] = -1; blk[20] = 7;
        run_block(-1, -1);
        clear_blk(); blk[63] = 1;
        run_block(-1, -1);
        gen_blk(30);
        run_block(-1, 12);
        clear_blk(); blk[0] = 2047; blk[5] = -2048; blk[40] = 2047;
        run_block(-1, -1);
        clear_blk(); blk[0] = -2048; blk[17] = -1; blk[63] = -2048;
        run_block(-1, 40);

        // Partial block discarded by a mid-block reset
        sb_en = 1'b0;
        gen_blk(20);
        for (int k = 0; k < 30; k++) send_coef(blk[k], 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        ref_pred = 0;
        pend_clr = 1'b0;
        check_reset_outputs();
        sb_en = 1'b1;
        @(negedge clk);

        clear_blk(); blk[0] = 4; blk[9] = 2;
        run_block(10, -1);
        gen_blk(25);
        run_block(-1, -1);

        for (int b = 0; b < 10; b++) begin
            gen_blk((b % 3 == 0) ? 4 : int'($urandom_range(5, 60)));
            run_block(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : -1,
                      ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 63)) : -1);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        #3;
        check_eq("idle_out_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jpeg_rle_encoder.md
Name: jpeg_rle_encoder

Overview:
- Run-length/category stage of the JPEG entropy path.
- Sits directly downstream of the quantizer/zig-zag logic and consumes its coefficient stream: 64 signed coefficients per 8x8 block, in zig-zag order.
- Produces Huffman-ready symbols (run, size, amplitude), including DC differential coding, ZRL (15/0) and EOB (0/0).
- Feeds the Huffman coder through a valid/ready handshake.

Parameters:
- COEF_W, 12, signed coefficient width. Amplitude output is COEF_W bits.
- SIZE_W, 4, width of the size category. Must be at least clog2(COEF_W+1).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- clr_pred  in  1  synchronous clear of the DC predictor to 0 (frame start or restart marker); takes effect at block boundaries only.
- in_valid  in  1  coefficient valid.
- in_ready  out  1  coefficient accepted when in_valid && in_ready.
- in_coef  in  COEF_W  signed quantized coefficient, zig-zag order.
- out_valid  out  1  symbol valid.
- out_ready  in  1  downstream accepts the symbol.
- out_run  out  4  zero run (0..15).
- out_size  out  SIZE_W  magnitude category (0..COEF_W).
- out_amp  out  COEF_W  amplitude bits, right-aligned.
- out_dc  out  1  symbol is the DC difference.
- out_last  out  1  final symbol of the block.

Behaviour:
- Reset: out_valid=0; out_run, out_size, out_amp, out_dc, out_last = 0; index=0; run=0; DC predictor=0; state=ACCEPT.
- Single output register. A slot is free when !out_valid || out_ready. out_valid/data hold stable until taken.
- States:
  - ACCEPT: in_ready = slot free.
  - FLUSH: in_ready = 0.
- Index counter 0..63 advances on each accepted coefficient and wraps 63 -> 0.
- Index 0 (DC):
  - diff = coef - pred, computed at COEF_W+1 bits.
  - Emit run=0, size=cat(diff), out_dc=1.
  - pred <= coef.
  - If clr_pred is high in the accept cycle, pred is treated as 0 for this diff.
  - clr_pred asserted outside index 0 is latched and applied at the next index-0 accept.
- Size category: cat(v) = number of bits of |v|; cat(0)=0.
- Amplitude: v >= 0 -> v; v < 0 -> (v-1) truncated to the low cat bits, upper bits zero.
- AC zero, index < 63: no output; run++.
- AC nonzero, run < 16: emit (run, cat, amp); run <= 0.
- AC nonzero, run >= 16:
  - Hold the coefficient internally.
  - Emit ZRL (run=15, size=0, amp=0); run -= 16; go to FLUSH.
  - FLUSH, on each free slot: if run >= 16, emit another ZRL; otherwise emit the held symbol, run=0, return to ACCEPT.
- Index 63:
  - Nonzero: its symbol is emitted with out_last=1 (after any ZRLs); no EOB.
  - Zero: emit EOB (0,0) with out_last=1. Pending ZRLs are discarded because the run never exceeds 62 without being flushed.
- Latency: a symbol is registered and visible on the cycle after its accept (or after its FLUSH step).
- Throughput: at most 1 symbol per cycle.
- Backpressure: out_ready low stalls both the input and FLUSH with no loss.
- rst mid-block: the partial block is discarded; the next coefficient is index 0 with pred=0.

Decomposition:
- Shared package jpeg_pkg:
  - BLOCK_COEFS = 64.
  - ZRL_RUN = 15.
  - The symbol struct {run, size, amp, dc, last}.
  - The state enum {ACCEPT, FLUSH}.
- Sub-module jpeg_size_cat: combinational, value -> (size, amp). Instantiated once and shared between the DC and AC paths.

Test Plan:
- DC only, pred=0: block = [5, 0 x 63] -> (0,3,101b,dc), then EOB with last=1; pred=5.
- Next block DC=3, all AC zero: diff=-2 -> (0,2,01b,dc), then EOB.
- AC runs: index1 = -1, index 20 = 7, rest 0 -> (0,1,0b), (0,3? no) ... (run 18): ZRL, then (2,3,111b), then EOB. in_ready is low during the ZRL flush.
- Index 63 nonzero: 62 zeros then coef=1 -> three ZRLs, (14,1,1b,last); no EOB.
- Backpressure: out_ready held 0 for 5 cycles mid-stream -> out_valid and symbol stable; in_ready=0; no symbols lost or duplicated versus the golden model.
- rst asserted at index 30, then a new block with DC=4 -> DC diff=4 (pred reset), index restarts at 0; clr_pred at index 10 -> the next block's DC diff uses pred=0.
